// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register family.
// Provides the operating-mode encoding, the burst FSM state type and
// shift_step(), the single-step next-value function reused by any block
// that needs the same step semantics.
package shift_pkg;

   // Widest register that shift_step() can operate on.
   localparam int MAX_W = 64;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'd0,
      MODE_SHL  = 3'd1,
      MODE_SHR  = 3'd2,
      MODE_ROL  = 3'd3,
      MODE_ROR  = 3'd4,
      MODE_ASR  = 3'd5,
      MODE_LOAD = 3'd6,
      MODE_CLR  = 3'd7
   } shift_mode_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } fsm_state_t;

   // One step of the selected mode on a register of 'width' bits.
   // Operands are carried right-aligned in MAX_W bits; the result is
   // masked so bits above 'width' are always zero.
   function automatic logic [MAX_W-1:0] shift_step(
      input logic [MAX_W-1:0] q,
      input shift_mode_t      mode,
      input logic             sin_l,
      input logic             sin_r,
      input logic [MAX_W-1:0] pdata,
      input int               width
   );
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] msb_pos;
      logic [MAX_W-1:0] qm;
      logic [MAX_W-1:0] res;
      logic             msb;
      mask    = (width >= MAX_W) ? {MAX_W{1'b1}}
                                 : ((MAX_W'(1) << width) - MAX_W'(1));
      msb_pos = MAX_W'(1) << (width - 1);
      qm      = q & mask;
      msb     = |(qm & msb_pos);
      case (mode)
         MODE_HOLD: res = qm;
         MODE_SHL:  res = (qm << 1) | MAX_W'(sin_r);
         MODE_SHR:  res = (qm >> 1) | (sin_l ? msb_pos : {MAX_W{1'b0}});
         MODE_ROL:  res = (qm << 1) | MAX_W'(msb);
         MODE_ROR:  res = (qm >> 1) | (qm[0] ? msb_pos : {MAX_W{1'b0}});
         MODE_ASR:  res = (qm >> 1) | (msb ? msb_pos : {MAX_W{1'b0}});
         MODE_LOAD: res = pdata;
         MODE_CLR:  res = {MAX_W{1'b0}};
         default:   res = {MAX_W{1'b0}};
      endcase
      return res & mask;
   endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step and burst operation.
// Ports:
//   clk, reset (async, active-low)
//   en     - single step of live 'mode' when idle
//   mode   - operation select (shift_mode_t encoding)
//   start  - begin a burst of 'amt' steps of 'mode' when idle
//   amt    - burst step count (0 gives an immediate done pulse)
//   sin_l  - serial in to MSB (SHR); sin_r - serial in to LSB (SHL)
//   pdata  - parallel load data
//   q      - register contents; sout_l/sout_r - q MSB/LSB
//   busy   - burst in progress; done - one-cycle burst completion pulse
module univ_shift_reg
   import shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             start,
   input  logic [CNT_W-1:0] amt,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic [WIDTH-1:0] pdata,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
);

   fsm_state_t       state;
   fsm_state_t       state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   shift_mode_t      mode_lat;
   shift_mode_t      mode_lat_next;
   shift_mode_t      step_mode;
   logic             step_en;
   logic [WIDTH-1:0] q_next;
   logic             done_next;

   // Next-state, counter and step selection for the IDLE/BUSY burst FSM.
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      mode_lat_next = mode_lat;
      step_mode     = shift_mode_t'(mode);
      step_en       = 1'b0;
      done_next     = 1'b0;
      case (state)
         ST_IDLE: begin
            // start wins over en and takes no step on its own edge
            if (start) begin
               mode_lat_next = shift_mode_t'(mode);
               cnt_next      = amt;
               if (amt != CNT_W'(0)) begin
                  state_next = ST_BUSY;
               end else begin
                  done_next  = 1'b1;
               end
            end else if (en) begin
               step_en = 1'b1;
            end else begin
               step_en = 1'b0;
            end
         end
         ST_BUSY: begin
            step_mode = mode_lat;
            step_en   = 1'b1;
            cnt_next  = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end else begin
               state_next = ST_BUSY;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = CNT_W'(0);
         end
      endcase
   end

   // Data path: apply one step of the selected mode when stepping.
   always_comb begin
      if (step_en) begin
         q_next = WIDTH'(shift_step(MAX_W'(q), step_mode, sin_l, sin_r,
                                    MAX_W'(pdata), WIDTH));
      end else begin
         q_next = q;
      end
   end

   // State, counter, data and status registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         cnt      <= CNT_W'(0);
         mode_lat <= MODE_HOLD;
         q        <= WIDTH'(0);
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         mode_lat <= mode_lat_next;
         q        <= q_next;
         busy     <= (state_next == ST_BUSY);
         done     <= done_next;
      end
   end

   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

   localparam int WIDTH = 8;
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             clk;
   logic             reset;
   logic             en;
   logic [2:0]       mode;
   logic             start;
   logic [CNT_W-1:0] amt;
   logic             sin_l;
   logic             sin_r;
   logic [WIDTH-1:0] pdata;
   logic [WIDTH-1:0] q;
   logic             sout_l;
   logic             sout_r;
   logic             busy;
   logic             done;

   int checks;
   int passed;

   univ_shift_reg #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .start(start),
      .amt(amt), .sin_l(sin_l), .sin_r(sin_r), .pdata(pdata),
      .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             en;
      logic             start;
      logic [2:0]       mode;
      logic [CNT_W-1:0] amt;
      logic             sin_l;
      logic             sin_r;
      logic [WIDTH-1:0] pdata;
      logic [WIDTH-1:0] exp_q;
      logic             exp_busy;
      logic             exp_done;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic e, input logic s, input logic [2:0] m,
                      input logic [CNT_W-1:0] a, input logic sl, input logic sr,
                      input logic [WIDTH-1:0] pd, input logic [WIDTH-1:0] eq,
                      input logic eb, input logic ed);
      vec_t v;
      v.en = e; v.start = s; v.mode = m; v.amt = a; v.sin_l = sl; v.sin_r = sr;
      v.pdata = pd; v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input logic e, input logic s, input logic [2:0] m,
                        input logic [CNT_W-1:0] a, input logic sl, input logic sr,
                        input logic [WIDTH-1:0] pd);
      en = e; start = s; mode = m; amt = a; sin_l = sl; sin_r = sr; pdata = pd;
   endtask

   task automatic check_all(input string tag, input logic [WIDTH-1:0] eq,
                            input logic eb, input logic ed);
      chk({tag, ".q"}, 32'(q), 32'(eq));
      chk({tag, ".busy"}, 32'(busy), 32'(eb));
      chk({tag, ".done"}, 32'(done), 32'(ed));
      chk({tag, ".sout_l"}, 32'(sout_l), 32'(eq[WIDTH-1]));
      chk({tag, ".sout_r"}, 32'(sout_r), 32'(eq[0]));
   endtask

   initial begin
      checks = 0;
      passed = 0;
      drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      //   en    start mode  amt  sl    sr    pdata  exp_q  busy  done
      add(1'b1, 1'b0, 3'd1, 4'd0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0); // SHL 1
      add(1'b1, 1'b0, 3'd1, 4'd0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0); // SHL 0
      add(1'b1, 1'b0, 3'd1, 4'd0, 1'b0, 1'b1, 8'h00, 8'h05, 1'b0, 1'b0); // SHL 1
      add(1'b1, 1'b0, 3'd1, 4'd0, 1'b0, 1'b1, 8'h00, 8'h0B, 1'b0, 1'b0); // SHL 1
      add(1'b1, 1'b0, 3'd2, 4'd0, 1'b1, 1'b0, 8'h00, 8'h85, 1'b0, 1'b0); // SHR sin_l=1
      add(1'b1, 1'b0, 3'd6, 4'd0, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0); // LOAD
      add(1'b0, 1'b1, 3'd3, 4'd3, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0); // start ROL 3
      add(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00, 8'h4B, 1'b1, 1'b0);
      add(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00, 8'h96, 1'b1, 1'b0);
      add(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00, 8'h2D, 1'b0, 1'b1);
      add(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00, 8'h2D, 1'b0, 1'b0); // done gone
      add(1'b1, 1'b0, 3'd6, 4'd0, 1'b0, 1'b0, 8'h80, 8'h80, 1'b0, 1'b0); // LOAD 80
      add(1'b0, 1'b1, 3'd5, 4'd2, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b0); // start ASR 2
      add(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00, 8'hC0, 1'b1, 1'b0);
      add(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00, 8'hE0, 1'b0, 1'b1);
      add(1'b1, 1'b0, 3'd6, 4'd0, 1'b0, 1'b0, 8'h80, 8'h80, 1'b0, 1'b0); // reload 80
      add(1'b0, 1'b1, 3'd2, 4'd2, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b0); // start SHR 2
      add(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00, 8'h40, 1'b1, 1'b0);
      add(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00, 8'h20, 1'b0, 1'b1);
      add(1'b0, 1'b1, 3'd7, 4'd0, 1'b0, 1'b0, 8'h00, 8'h20, 1'b0, 1'b1); // start amt=0 while done high
      add(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00, 8'h20, 1'b0, 1'b0);
      add(1'b1, 1'b0, 3'd6, 4'd0, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b0); // LOAD 3C
      add(1'b0, 1'b1, 3'd4, 4'd4, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b1, 1'b0); // start ROR 4
      add(1'b1, 1'b1, 3'd7, 4'd2, 1'b0, 1'b0, 8'hFF, 8'h1E, 1'b1, 1'b0); // ignored start/en
      add(1'b1, 1'b1, 3'd7, 4'd2, 1'b0, 1'b0, 8'hFF, 8'h0F, 1'b1, 1'b0);
      add(1'b0, 1'b0, 3'd6, 4'd0, 1'b0, 1'b0, 8'hFF, 8'h87, 1'b1, 1'b0);
      add(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b0, 1'b1);
      add(1'b0, 1'b0, 3'd6, 4'd0, 1'b0, 1'b0, 8'hFF, 8'hC3, 1'b0, 1'b0); // en=0 holds
      add(1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 1'b1, 8'hFF, 8'hC3, 1'b0, 1'b0); // HOLD mode
      add(1'b1, 1'b0, 3'd3, 4'd0, 1'b0, 1'b0, 8'h00, 8'h87, 1'b0, 1'b0); // ROL single
      add(1'b1, 1'b0, 3'd4, 4'd0, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b0, 1'b0); // ROR single
      add(1'b1, 1'b0, 3'd7, 4'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0); // CLR

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].en, vecs[i].start, vecs[i].mode, vecs[i].amt,
               vecs[i].sin_l, vecs[i].sin_r, vecs[i].pdata);
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_busy, vecs[i].exp_done);
      end

      // Abort: reset two steps into a 5-step ROL burst.
      drive(1'b1, 1'b0, 3'd6, 4'd0, 1'b0, 1'b0, 8'h5A);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 3'd3, 4'd5, 1'b0, 1'b0, 8'h00);
      @(posedge clk); #1;
      check_all("abort.start", 8'h5A, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00);
      @(posedge clk); #1;
      check_all("abort.step1", 8'hB4, 1'b1, 1'b0);
      @(posedge clk); #1;
      check_all("abort.step2", 8'h69, 1'b1, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check_all("abort.async", 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check_all($sformatf("abort.after%0d", i), 8'h00, 1'b0, 1'b0);
      end

      // Next burst after abort behaves normally: SHL x2 with sin_r=1.
      drive(1'b1, 1'b0, 3'd6, 4'd0, 1'b0, 1'b0, 8'h01);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 3'd1, 4'd2, 1'b0, 1'b1, 8'h00);
      @(posedge clk); #1;
      check_all("post.start", 8'h01, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 8'h00);
      @(posedge clk); #1;
      check_all("post.step1", 8'h03, 1'b1, 1'b0);
      @(posedge clk); #1;
      check_all("post.step2", 8'h07, 1'b0, 1'b1);
      @(posedge clk); #1;
      check_all("post.idle", 8'h07, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register, the next generation of the team's 4-bit serial-in shift register. It adds configurable width, eight operating modes (shift, rotate, arithmetic shift, parallel load, clear) and a multi-cycle burst operation that performs N steps with busy/done status. It sits between serial links and parallel datapaths, and also serves as a barrel-shifter substitute in low-area control logic.

## Interface
- `WIDTH`, 8: register width in bits; ≥ 2.
- `CNT_W`, `$clog2(WIDTH+1)`: burst-count width; derived, not overridden.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  single-step enable; honoured only when idle.
- `mode`  in  3  operation select (see Operation).
- `start`  in  1  begin a burst of `amt` steps; honoured only when idle.
- `amt`  in  CNT_W  burst step count; sampled with `start`.
- `sin_l`  in  1  serial input into the MSB (SHR).
- `sin_r`  in  1  serial input into the LSB (SHL).
- `pdata`  in  WIDTH  parallel load data.
- `q`  out  WIDTH  register contents.
- `sout_l`  out  1  `q[WIDTH-1]`, combinational from `q`.
- `sout_r`  out  1  `q[0]`, combinational from `q`.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse at burst completion.

## Operation
- Mode encodings and step results:
  - 0 HOLD: q unchanged.
  - 1 SHL: `{q[W-2:0], sin_r}`.
  - 2 SHR: `{sin_l, q[W-1:1]}`.
  - 3 ROL: `{q[W-2:0], q[W-1]}`.
  - 4 ROR: `{q[0], q[W-1:1]}`.
  - 5 ASR: `{q[W-1], q[W-1:1]}`.
  - 6 LOAD: `pdata`.
  - 7 CLR: 0.
- FSM states:
  - IDLE:
    - `start`=1 latches `mode` and `amt`.
    - If `amt`≠0, go to BUSY. If `amt`=0, stay IDLE and pulse `done`.
    - `start` has priority over `en`; no step is taken on the `start` edge.
    - Otherwise, `en`=1 applies one step of the live `mode` per edge. `en`=0 holds.
  - BUSY:
    - Each edge applies one step of the latched mode and decrements the counter.
    - `sin_l`, `sin_r` and `pdata` are sampled live at each step.
    - After the step that brings the counter to 0, go to IDLE and assert `done` for one cycle.
    - `start`, `en`, `mode` and `amt` are ignored while BUSY.
- `amt` is not clamped to WIDTH. Rotating by `amt` > WIDTH is legal and wraps naturally.
- Reset (any time, including mid-burst) sets `q`=0, `busy`=0, `done`=0, counter=0, state IDLE. An aborted burst produces no `done`.

## Timing
- Single step: `q` updates on the edge where `en`=1; latency 1.
- Burst with `start` at edge E0 and `amt`=N≥1:
  - `busy`=1 after E0 through edge E0+N.
  - Steps occur at edges E0+1 … E0+N.
  - `busy`=0 and `done`=1 for the cycle after E0+N.
  - A new `start` is accepted at edge E0+N+1, i.e. while `done` is high.
- `amt`=0: `done`=1 for the cycle after E0; `busy` never rises.
- Reset values: `q`=0, `busy`=0, `done`=0. `sout_l` and `sout_r` follow `q`, so both are 0.

## Structure
- Shared package `shift_pkg`:
  - `shift_mode_t` enum with MODE_HOLD … MODE_CLR at encodings 0–7.
  - Function `shift_step(q, mode, sin_l, sin_r, pdata)` returning the next value, so other blocks reuse the step logic.
- Single module. The FSM is IDLE/BUSY plus a down-counter. No sub-module.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert `reset`=0 mid-operation → `q`=0x00, `busy`=0, `done`=0 immediately; release → `q` holds 0x00.
- Serial shift-in: `en`=1, SHL, `sin_r` = 1,0,1,1 over 4 edges → `q`=0x0B, `sout_r`=1. Then SHR with `sin_l`=1 for 1 edge → `q`=0x85.
- Burst rotate:
  - LOAD 0xA5 via `en`.
  - `start`, ROL, `amt`=3 → `busy` high for 3 cycles, `q` = 0x4B, 0x96, 0x2D.
  - `done` high exactly 1 cycle, coincident with `busy` falling.
- Arithmetic vs logical: `q`=0x80, `start` ASR `amt`=2 → `q`=0xE0. Reload 0x80, `start` SHR `amt`=2 with `sin_l`=0 → `q`=0x20.
- Zero and ignore:
  - `start` with `amt`=0 → `done` pulses next cycle, `q` unchanged, `busy` stays 0.
  - While BUSY (ROR `amt`=4), pulse `start` (CLR) and `en` → both ignored, final `q` = input rotated right by 4.
- Abort: reset asserted during an `amt`=5 burst after 2 steps → `q`=0, `busy`=0, no `done` pulse afterwards. The next `start` behaves normally.
